// File: rtl/nmi_arb_pkg.sv
// Shared types and defaults for the NMI round-robin arbiter.
package nmi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ABORT
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          ARB_TIMEOUT_DEF  = 1024;

endpackage

// File: rtl/nmi_rr_pick.sv
// Rotated priority encoder: first asserted request at or after i_ptr, wrapping modulo N.
// Purely combinational, no backpressure of its own.
module nmi_rr_pick
  import nmi_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_vld = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/nmi_rr_arbiter.sv
// N-master round-robin NMI arbiter: one arbitration cycle, grant held until ready, valid drop or watchdog abort.
// Non-granted masters see ready=0 until their turn; a stuck slave is cut off after TIMEOUT_CYC cycles.
module nmi_rr_arbiter
  import nmi_arb_pkg::*;
#(
  parameter  int                N_MSTR      = 2,
  parameter  int                ADDR_W      = 32,
  parameter  int                DATA_W      = 32,
  parameter  int                TIMEOUT_CYC = ARB_TIMEOUT_DEF,
  parameter  logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ARB_ERR_DATA_DEF),
  localparam int                STRB_W      = DATA_W / 8,
  localparam int                IDX_W       = $clog2(N_MSTR)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_MSTR-1:0]          m_valid_i,
  input  logic [N_MSTR*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MSTR*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MSTR*STRB_W-1:0]   m_wstrb_i,
  output logic [N_MSTR-1:0]          m_ready_o,
  output logic [N_MSTR*DATA_W-1:0]   m_rdata_o,
  output logic                       s_valid_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  output logic [STRB_W-1:0]          s_wstrb_o,
  input  logic                       s_ready_i,
  input  logic [DATA_W-1:0]          s_rdata_i,
  output logic [IDX_W-1:0]           gnt_id_o,
  output logic                       tmo_o,
  output logic [IDX_W-1:0]           tmo_id_o,
  input  logic                       tmo_clr_i
);

  localparam bit             WD_EN    = (TIMEOUT_CYC != 0);
  localparam int             CNT_W    = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt_id;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;
  logic [IDX_W-1:0] r_tmo_id;

  logic             w_pick_vld;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_gnt_vld;
  logic             w_done;
  logic             w_drop;
  logic             w_expire;
  logic [IDX_W-1:0] w_nxt_ptr;

  nmi_rr_pick #(.N(N_MSTR)) u_pick (
    .i_req (m_valid_i),
    .i_ptr (r_rr_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  assign w_gnt_vld = m_valid_i[r_gnt_id];
  assign w_done    = w_gnt_vld && s_ready_i;
  assign w_drop    = !w_gnt_vld;
  assign w_expire  = WD_EN && (r_cnt == CNT_LAST) && !s_ready_i;
  assign w_nxt_ptr = (r_gnt_id == IDX_W'(N_MSTR - 1)) ? '0 : r_gnt_id + IDX_W'(1);

  always_comb begin
    s_valid_o = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    m_ready_o = '0;
    m_rdata_o = '0;
    case (r_state)
      ARB_GRANT: begin
        s_valid_o = w_gnt_vld;
        s_addr_o  = m_addr_i[r_gnt_id*ADDR_W +: ADDR_W];
        s_wdata_o = m_wdata_i[r_gnt_id*DATA_W +: DATA_W];
        s_wstrb_o = m_wstrb_i[r_gnt_id*STRB_W +: STRB_W];
        // A ready seen after the master withdrew must not be reported as a completion.
        m_ready_o[r_gnt_id] = s_ready_i && w_gnt_vld;
        m_rdata_o[r_gnt_id*DATA_W +: DATA_W] = s_rdata_i;
      end
      ARB_ABORT: begin
        m_ready_o[r_gnt_id] = 1'b1;
        m_rdata_o[r_gnt_id*DATA_W +: DATA_W] = ERR_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
      r_tmo_id <= '0;
    end else begin
      if (tmo_clr_i) r_tmo <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_vld) begin
            r_gnt_id <= w_pick_idx;
            r_state  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_done || w_drop) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_nxt_ptr;
            r_cnt    <= '0;
          end else if (w_expire) begin
            r_state <= ARB_ABORT;
            r_cnt   <= '0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ARB_ABORT: begin
          // Written after the clear so a coincident timeout keeps the flag set.
          r_tmo    <= 1'b1;
          r_tmo_id <= r_gnt_id;
          r_state  <= ARB_IDLE;
          r_rr_ptr <= w_nxt_ptr;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_id_o = r_gnt_id;
  assign tmo_o    = r_tmo;
  assign tmo_id_o = r_tmo_id;

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a transaction-level model.
module tb_nmi_rr_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int IW  = $clog2(N);
  localparam int TMO = 8;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_valid = '0;
  logic [N*AW-1:0] m_addr  = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*SW-1:0] m_wstrb = '0;
  logic [N-1:0]    m_ready;
  logic [N*DW-1:0] m_rdata;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic [IW-1:0]   gnt_id;
  logic            tmo;
  logic [IW-1:0]   tmo_id;
  logic            tmo_clr = 1'b0;

  always #5 clk = ~clk;

  nmi_rr_arbiter #(
    .N_MSTR(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO), .ERR_DATA(ERR)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_ready_o(m_ready), .m_rdata_o(m_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata),
    .gnt_id_o(gnt_id), .tmo_o(tmo), .tmo_id_o(tmo_id), .tmo_clr_i(tmo_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner of the bus (-1 = nobody), whether its transfer is being aborted,
  // cycles waited, who gets first look next, and the sticky timeout record.
  int md_owner  = -1;
  bit md_abort  = 1'b0;
  int md_wait   = 0;
  int md_nxt    = 0;
  int md_gnt    = 0;
  bit md_tmo    = 1'b0;
  int md_tmo_id = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic            granted;
    logic            ev;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ew;
    logic [SW-1:0]   es;
    logic [N-1:0]    er;
    logic [N*DW-1:0] ed;
    granted = (md_owner >= 0) && !md_abort;
    ev = 1'b0; ea = '0; ew = '0; es = '0; er = '0; ed = '0;
    if (granted) begin
      ev = m_valid[md_owner];
      ea = m_addr[md_owner*AW +: AW];
      ew = m_wdata[md_owner*DW +: DW];
      es = m_wstrb[md_owner*SW +: SW];
      er[md_owner] = s_ready && m_valid[md_owner];
      ed[md_owner*DW +: DW] = s_rdata;
    end
    if (md_abort) begin
      er[md_owner] = 1'b1;
      ed[md_owner*DW +: DW] = ERR;
    end
    chk("s_valid", s_valid, ev);
    chk("s_addr",  s_addr,  ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_wstrb", s_wstrb, es);
    chk("m_ready", m_ready, er);
    chk("m_rdata", m_rdata, ed);
    chk("gnt_id",  gnt_id,  md_gnt);
    chk("tmo",     tmo,     md_tmo);
    chk("tmo_id",  tmo_id,  md_tmo_id);
  endtask

  task automatic model_clock();
    if (rst) begin
      md_owner = -1; md_abort = 1'b0; md_wait = 0; md_nxt = 0;
      md_gnt = 0; md_tmo = 1'b0; md_tmo_id = 0;
      return;
    end
    if (tmo_clr) md_tmo = 1'b0;
    if (md_abort) begin
      md_tmo = 1'b1;
      md_tmo_id = md_owner;
      md_nxt = (md_owner + 1) % N;
      md_owner = -1;
      md_abort = 1'b0;
    end else if (md_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (md_owner < 0 && m_valid[(md_nxt + i) % N]) begin
          md_owner = (md_nxt + i) % N;
          md_gnt = md_owner;
          md_wait = 0;
        end
      end
    end else if (!m_valid[md_owner] || s_ready) begin
      md_nxt = (md_owner + 1) % N;
      md_owner = -1;
    end else if (md_wait == TMO - 1) begin
      md_abort = 1'b1;
    end else begin
      md_wait++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic cyc();
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic step();
    settle();
    cyc();
  endtask

  initial begin
    int c0;
    int c1;
    int rdy_pct;

    // Reset
    step();
    step();
    rst = 1'b0;

    // Single master, ready on third GRANT cycle
    m_valid = 3'b001;
    m_addr[0 +: AW] = 32'h3000_0010;
    m_wdata[0 +: DW] = 32'hA5A5_0001;
    s_rdata = 32'h1234_5678;
    step();
    settle();
    chk("t1_svld_c1", s_valid, 1'b1);
    cyc();
    step();
    s_ready = 1'b1;
    settle();
    chk("t1_ready", m_ready, 3'b001);
    chk("t1_rdata", m_rdata[31:0], 32'h1234_5678);
    chk("t1_gnt", gnt_id, 0);
    cyc();
    s_ready = 1'b0;
    m_valid = '0;
    step();

    // Two masters contending on a zero-wait slave
    c0 = 0;
    c1 = 0;
    m_valid = 3'b011;
    s_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_addr = {$urandom, $urandom, $urandom};
      settle();
      c0 += int'(m_ready[0]);
      c1 += int'(m_ready[1]);
      cyc();
    end
    chk("t2_m0_cnt", c0, 4);
    chk("t2_m1_cnt", c1, 4);
    m_valid = '0;
    s_ready = 1'b0;
    step();

    // Wrap: pointer left at 2, masters 0 and 1 requesting
    m_valid = 3'b010;
    s_ready = 1'b1;
    step();
    step();
    m_valid = 3'b011;
    step();
    settle();
    chk("t3_wrap0", gnt_id, 0);
    cyc();
    step();
    settle();
    chk("t3_then1", gnt_id, 1);
    cyc();
    m_valid = '0;
    s_ready = 1'b0;

    // Watchdog abort on master 1
    m_valid = 3'b010;
    step();
    for (int i = 0; i < TMO; i++) step();
    settle();
    chk("t4_abort_rdy", m_ready, 3'b010);
    chk("t4_abort_data", m_rdata[63:32], ERR);
    chk("t4_abort_svld", s_valid, 1'b0);
    cyc();
    m_valid = '0;
    settle();
    chk("t4_tmo", tmo, 1'b1);
    chk("t4_tmo_id", tmo_id, 1);
    cyc();
    tmo_clr = 1'b1;
    step();
    tmo_clr = 1'b0;
    settle();
    chk("t4_tmo_clr", tmo, 1'b0);
    cyc();

    // Master 0 withdraws mid-grant
    m_valid = 3'b001;
    step();
    step();
    step();
    m_valid = 3'b010;
    settle();
    chk("t5_no_rdy", m_ready, 3'b000);
    cyc();
    step();
    settle();
    chk("t5_next1", gnt_id, 1);
    cyc();
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    m_valid = '0;
    step();

    // Reset during a grant, then a late ready in IDLE
    m_valid = 3'b001;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = '0;
    s_ready = 1'b1;
    settle();
    chk("t6_svld", s_valid, 1'b0);
    chk("t6_mrdy", m_ready, 3'b000);
    chk("t6_rdata", m_rdata, '0);
    cyc();
    m_valid = 3'b011;
    s_ready = 1'b0;
    step();
    settle();
    chk("t6_gnt0", gnt_id, 0);
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rdy_pct = ((i / 500) % 2 == 1) ? 3 : 40;
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) m_valid[k] = ~m_valid[k];
      end
      m_addr  = {$urandom, $urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom};
      m_wstrb = N*SW'($urandom);
      s_rdata = $urandom;
      s_ready = ($urandom_range(0, 99) < rdy_pct);
      tmo_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
